// File: rtl/simd_mpy_pipe.sv
// SIMD 16x16 multiply pipeline.
// Each 32-bit lane computes its product when the instruction is issued. The
// result then travels down a LAT_L-deep register chain. Short-class results
// leave on the rt_wb port from stage LAT_S-1. Long-class results leave on the
// rt_int port from stage LAT_L-1.
//
// Bit numbering: opcode and address strings are written MSB-first. Opcode
// string character 0 is op[10] and character 10 is op[0]. Data lane i sits at
// bits [32*i +: 32] of each operand and result bus.
module simd_mpy_pipe #(
    parameter int LANES = 4,
    parameter int LAT_S = 6,
    parameter int LAT_L = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           op,
    input  logic [2:0]            format,
    input  logic [6:0]            rt_addr,
    input  logic [LANES*32-1:0]   ra,
    input  logic [LANES*32-1:0]   rb,
    input  logic [LANES*32-1:0]   rc,
    input  logic                  reg_write,
    input  logic                  stall,
    input  logic                  flush,
    output logic [LANES*32-1:0]   rt_wb,
    output logic [6:0]            rt_addr_wb,
    output logic                  reg_write_wb,
    output logic [LANES*32-1:0]   rt_int,
    output logic [6:0]            rt_addr_int,
    output logic                  reg_write_int
);

    localparam int W = LANES * 32;

    localparam logic [10:0] OP_MPY   = 11'b01111000100;
    localparam logic [10:0] OP_MPYU  = 11'b01111001100;
    localparam logic [10:0] OP_MPYH  = 11'b01111000101;
    localparam logic [10:0] OP_MPYHH = 11'b01111000110;
    localparam logic [10:0] OP_MPYS  = 11'b01111000111;

    typedef enum logic [2:0] {
        K_NONE, K_MPY, K_MPYU, K_MPYH, K_MPYHH, K_MPYS, K_MPYA
    } kind_e;

    typedef struct packed {
        logic [W-1:0] data;
        logic [6:0]   addr;
        logic         we;
        logic         vld;
        logic         lng;
    } stage_t;

    kind_e  kind;
    logic [W-1:0] res;
    stage_t ent_d;
    stage_t st_q [LAT_L];

    function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
        return {{16{a[15]}}, a} * {{16{b[15]}}, b};
    endfunction

    function automatic logic [31:0] umul(input logic [15:0] a, input logic [15:0] b);
        return {16'h0, a} * {16'h0, b};
    endfunction

    // Decode the opcode into an operation kind. A nop and any unrecognised
    // opcode both decode to K_NONE, and K_NONE enters the pipe as a bubble.
    always_comb begin
        kind = K_NONE;
        if (format == 3'd0) begin
            case (op)
                OP_MPY:   kind = K_MPY;
                OP_MPYU:  kind = K_MPYU;
                OP_MPYH:  kind = K_MPYH;
                OP_MPYHH: kind = K_MPYHH;
                OP_MPYS:  kind = K_MPYS;
                default:  kind = K_NONE;
            endcase
        end else if (format == 3'd1 && op[10:7] == 4'b1100) begin
            kind = K_MPYA;
        end
    end

    // Compute the per-lane products for the instruction being issued.
    always_comb begin
        logic [31:0] a, b, c, ll, hl, r;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            a  = ra[32*i +: 32];
            b  = rb[32*i +: 32];
            c  = rc[32*i +: 32];
            ll = smul(a[15:0], b[15:0]);
            hl = umul(a[31:16], b[15:0]);
            r  = '0;
            case (kind)
                K_MPY:   r = ll;
                K_MPYU:  r = umul(a[15:0], b[15:0]);
                K_MPYH:  r = {hl[15:0], 16'h0};
                K_MPYHH: r = smul(a[31:16], b[31:16]);
                K_MPYS:  r = {{16{ll[31]}}, ll[31:16]};
                K_MPYA:  r = ll + c;
                default: r = '0;
            endcase
            res[32*i +: 32] = r;
        end
    end

    // Build the stage-0 entry. A bubble has every field zero.
    always_comb begin
        ent_d = '0;
        if (kind != K_NONE) begin
            ent_d.data = res;
            ent_d.addr = rt_addr;
            ent_d.we   = reg_write;
            ent_d.vld  = 1'b1;
            ent_d.lng  = (kind == K_MPY) || (kind == K_MPYU) ||
                         (kind == K_MPYHH) || (kind == K_MPYA);
        end
    end

    // Advance the register chain. Flush takes priority over stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT_L; i++) st_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < LAT_L; i++) st_q[i] <= '0;
        end else if (!stall) begin
            st_q[0] <= ent_d;
            for (int i = 1; i < LAT_L; i++) st_q[i] <= st_q[i-1];
        end
    end

    // The ports come straight from stage flops through a class gate, so no
    // input reaches an output combinationally.
    always_comb begin
        rt_wb         = '0;
        rt_addr_wb    = '0;
        reg_write_wb  = 1'b0;
        rt_int        = '0;
        rt_addr_int   = '0;
        reg_write_int = 1'b0;
        if (st_q[LAT_S-1].vld && !st_q[LAT_S-1].lng) begin
            rt_wb        = st_q[LAT_S-1].data;
            rt_addr_wb   = st_q[LAT_S-1].addr;
            reg_write_wb = st_q[LAT_S-1].we;
        end
        if (st_q[LAT_L-1].vld && st_q[LAT_L-1].lng) begin
            rt_int        = st_q[LAT_L-1].data;
            rt_addr_int   = st_q[LAT_L-1].addr;
            reg_write_int = st_q[LAT_L-1].we;
        end
    end

endmodule

// File: tb/tb_simd_mpy_pipe.sv
// Directed bench for simd_mpy_pipe. It uses a 4-lane instance for most
// vectors and an 8-lane instance for the wide mpyu vector.
module tb_simd_mpy_pipe;

    localparam int LANES = 4;
    localparam int W     = LANES * 32;
    localparam int W8    = 8 * 32;
    localparam int LAT_S = 6;
    localparam int LAT_L = 7;

    localparam logic [10:0] OP_MPY   = 11'b01111000100;
    localparam logic [10:0] OP_MPYU  = 11'b01111001100;
    localparam logic [10:0] OP_MPYH  = 11'b01111000101;
    localparam logic [10:0] OP_MPYHH = 11'b01111000110;
    localparam logic [10:0] OP_MPYS  = 11'b01111000111;
    localparam logic [10:0] OP_MPYA  = 11'b11000000000;

    logic clk = 1'b0;
    logic reset;
    logic [10:0] op;
    logic [2:0]  format;
    logic [6:0]  rt_addr;
    logic [W-1:0] ra, rb, rc;
    logic reg_write, stall, flush;
    logic [W-1:0] rt_wb, rt_int;
    logic [6:0]  rt_addr_wb, rt_addr_int;
    logic reg_write_wb, reg_write_int;

    logic [W8-1:0] ra8, rb8, rc8, rt_wb8, rt_int8;
    logic [6:0]  rt_addr_wb8, rt_addr_int8;
    logic reg_write_wb8, reg_write_int8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simd_mpy_pipe #(.LANES(LANES), .LAT_S(LAT_S), .LAT_L(LAT_L)) u_dut (
        .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
        .ra(ra), .rb(rb), .rc(rc), .reg_write(reg_write), .stall(stall), .flush(flush),
        .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
        .rt_int(rt_int), .rt_addr_int(rt_addr_int), .reg_write_int(reg_write_int)
    );

    simd_mpy_pipe #(.LANES(8), .LAT_S(LAT_S), .LAT_L(LAT_L)) u_dut8 (
        .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
        .ra(ra8), .rb(rb8), .rc(rc8), .reg_write(reg_write), .stall(stall), .flush(flush),
        .rt_wb(rt_wb8), .rt_addr_wb(rt_addr_wb8), .reg_write_wb(reg_write_wb8),
        .rt_int(rt_int8), .rt_addr_int(rt_addr_int8), .reg_write_int(reg_write_int8)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [31:0] w);
        return {LANES{w}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op = '0; format = '0; rt_addr = '0; reg_write = 1'b0;
        ra = '0; rb = '0; rc = '0;
    endtask

    task automatic issue(input logic [10:0] o, input logic [2:0] f, input logic [6:0] ad,
                         input logic w, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
        op = o; format = f; rt_addr = ad; reg_write = w; ra = a; rb = b; rc = c;
        step();
        idle();
    endtask

    // k counts advancing edges since issue; the caller is already at edge k0.
    task automatic watch(input string tag, input int k0, input int ks, input int kl,
                         input logic [W-1:0] es, input logic [W-1:0] el,
                         input logic [6:0] as, input logic [6:0] al,
                         input logic ws, input logic wl);
        for (int k = k0; k <= LAT_L + 1; k++) begin
            chk({tag, "_wb"},    rt_wb,         (k == ks) ? es : '0);
            chk({tag, "_awb"},   rt_addr_wb,    (k == ks) ? as : 7'd0);
            chk({tag, "_wewb"},  reg_write_wb,  (k == ks) ? ws : 1'b0);
            chk({tag, "_int"},   rt_int,        (k == kl) ? el : '0);
            chk({tag, "_aint"},  rt_addr_int,   (k == kl) ? al : 7'd0);
            chk({tag, "_weint"}, reg_write_int, (k == kl) ? wl : 1'b0);
            if (k <= LAT_L) step();
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        idle();
        ra8 = '0; rb8 = '0; rc8 = '0;

        // reset state
        #23;
        chk("rst_wb", rt_wb, '0);
        chk("rst_int", rt_int, '0);
        chk("rst_addr", {rt_addr_wb, rt_addr_int}, 14'd0);
        chk("rst_we", {reg_write_wb, reg_write_int}, 2'd0);
        chk("rst_w8", {rt_wb8, rt_int8}, '0);
        #5 reset = 1'b1;

        // mpy: long class, first edge after reset
        issue(OP_MPY, 3'd0, 7'd5, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        watch("mpy", 1, 0, 7, '0, rep(32'hFFFFFFFE), 7'd0, 7'd5, 1'b0, 1'b1);

        // mpys: short class, arithmetic shift
        issue(OP_MPYS, 3'd0, 7'd9, 1'b1, rep(32'h00004000), rep(32'h00008000), '0);
        watch("mpys", 1, 6, 0, rep(32'hFFFFE000), '0, 7'd9, 7'd0, 1'b1, 1'b0);

        // mpya then mpyh: both ports in the same cycle
        issue(OP_MPYA, 3'd1, 7'd3, 1'b1, rep(32'h00030003), rep(32'h00050005), rep(32'h1));
        issue(OP_MPYH, 3'd0, 7'd4, 1'b1, rep(32'h00030003), rep(32'h00050005), '0);
        watch("dual", 2, 7, 7, rep(32'h000F0000), rep(32'h00000010), 7'd4, 7'd3, 1'b1, 1'b1);

        // mpyhh with reg_write 0 still drives data and addr
        issue(OP_MPYHH, 3'd0, 7'd7, 1'b0, rep(32'hFFFF0000), rep(32'h00070000), '0);
        watch("mpyhh", 1, 0, 7, '0, rep(32'hFFFFFFF9), 7'd0, 7'd7, 1'b0, 1'b0);

        // distinct per-lane operands: signed vs unsigned vs high-half
        issue(OP_MPY, 3'd0, 7'd10, 1'b1,
              {32'h0000FFFF, 32'h12340010, 32'h00008000, 32'h00000003},
              {32'h00008000, 32'h0000FFFF, 32'h00000002, 32'h00000004}, '0);
        watch("lanes_mpy", 1, 0, 7, '0,
              {32'h00008000, 32'hFFFFFFF0, 32'hFFFF0000, 32'h0000000C},
              7'd0, 7'd10, 1'b0, 1'b1);
        issue(OP_MPYU, 3'd0, 7'd11, 1'b1,
              {32'h0000FFFF, 32'h12340010, 32'h00008000, 32'h00000003},
              {32'h00008000, 32'h0000FFFF, 32'h00000002, 32'h00000004}, '0);
        watch("lanes_mpyu", 1, 0, 7, '0,
              {32'h7FFF8000, 32'h000FFFF0, 32'h00010000, 32'h0000000C},
              7'd0, 7'd11, 1'b0, 1'b1);
        issue(OP_MPYH, 3'd0, 7'd12, 1'b1,
              {32'h0000FFFF, 32'h12340010, 32'h00008000, 32'h00000003},
              {32'h00008000, 32'h0000FFFF, 32'h00000002, 32'h00000004}, '0);
        watch("lanes_mpyh", 1, 6, 0,
              {32'h00000000, 32'hEDCC0000, 32'h00000000, 32'h00000000}, '0,
              7'd12, 7'd0, 1'b1, 1'b0);

        // unknown opcodes and nop produce nothing
        issue(11'b01111000000, 3'd0, 7'd1, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        watch("unk0", 1, 0, 0, '0, '0, 7'd0, 7'd0, 1'b0, 1'b0);
        issue(OP_MPYA, 3'd2, 7'd1, 1'b1, rep(32'h0000FFFF), rep(32'h2), rep(32'h1));
        watch("unkfmt", 1, 0, 0, '0, '0, 7'd0, 7'd0, 1'b0, 1'b0);
        issue(OP_MPY, 3'd1, 7'd1, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        watch("unkf1", 1, 0, 0, '0, '0, 7'd0, 7'd0, 1'b0, 1'b0);
        issue(11'b00000000001, 3'd0, 7'd2, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        watch("nop", 1, 0, 0, '0, '0, 7'd0, 7'd0, 1'b0, 1'b0);

        // stall three cycles with the entry in stage 1; inputs are ignored while stalled
        issue(OP_MPY, 3'd0, 7'd5, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        step();
        stall = 1'b1;
        op = OP_MPYH; ra = rep(32'h00030003); rb = rep(32'h00050005); rt_addr = 7'd4; reg_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_hold_int", rt_int, '0);
            chk("stl_hold_wb", rt_wb, '0);
        end
        stall = 1'b0;
        idle();
        for (int a = 3; a <= LAT_L; a++) begin
            step();
            chk("stl_int", rt_int, (a == LAT_L) ? rep(32'hFFFFFFFE) : '0);
            chk("stl_wb", rt_wb, '0);
        end
        chk("stl_aint", rt_addr_int, 7'd5);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stl_outhold", rt_int, rep(32'hFFFFFFFE));
            chk("stl_outhold_a", rt_addr_int, 7'd5);
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_once_int", rt_int, '0);
            chk("stl_once_wb", rt_wb, '0);
        end

        // flush with four in flight, stall also high, a live input dropped
        issue(OP_MPY,  3'd0, 7'd1, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        issue(OP_MPYS, 3'd0, 7'd2, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        issue(OP_MPYH, 3'd0, 7'd3, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        issue(OP_MPYU, 3'd0, 7'd4, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        op = OP_MPY; ra = rep(32'h0000FFFF); rb = rep(32'h2); rt_addr = 7'd6; reg_write = 1'b1;
        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        idle();
        chk("fl_wb", rt_wb, '0);
        chk("fl_int", rt_int, '0);
        issue(OP_MPYS, 3'd0, 7'd9, 1'b1, rep(32'h00004000), rep(32'h00008000), '0);
        watch("postfl", 1, 6, 0, rep(32'hFFFFE000), '0, 7'd9, 7'd0, 1'b1, 1'b0);

        // reset asserted mid-flight discards everything
        issue(OP_MPY, 3'd0, 7'd5, 1'b1, rep(32'h0000FFFF), rep(32'h2), '0);
        issue(OP_MPYS, 3'd0, 7'd9, 1'b1, rep(32'h00004000), rep(32'h00008000), '0);
        step();
        #2 reset = 1'b0;
        #1;
        chk("mrst_int", rt_int, '0);
        chk("mrst_wb", rt_wb, '0);
        step();
        #2 reset = 1'b1;
        for (int i = 0; i < LAT_L + 1; i++) begin
            step();
            chk("mrst_after_int", rt_int, '0);
            chk("mrst_after_wb", rt_wb, '0);
        end

        // eight lanes, mpyu on 0xFFFF operands
        ra8 = {8{32'h0000FFFF}}; rb8 = {8{32'h0000FFFF}};
        issue(OP_MPYU, 3'd0, 7'd8, 1'b1, '0, '0, '0);
        ra8 = '0; rb8 = '0;
        for (int k = 1; k <= LAT_L; k++) begin
            chk("w8_int", rt_int8, (k == LAT_L) ? {8{32'hFFFE0001}} : '0);
            chk("w8_wb", rt_wb8, '0);
            if (k < LAT_L) step();
        end
        chk("w8_aint", rt_addr_int8, 7'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simd_mpy_pipe.md
SIMD_MPY_PIPE -- requirements
Module: simd_mpy_pipe

Interface
REQ-001 SHALL provide parameter LANES, default 4, number of 32-bit word lanes; datapath width W = LANES*32.
REQ-002 SHALL provide parameter LAT_S, default 6, short-class latency in cycles.
REQ-003 SHALL provide parameter LAT_L, default 7, long-class latency in cycles; legal range 2 <= LAT_S < LAT_L <= 16.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 op  in  11 [0:10]  decoded opcode.
REQ-007 format  in  3  instruction format: 0 = RR, 1 = RRR.
REQ-008 rt_addr  in  7 [0:6]  destination register address.
REQ-009 ra, rb, rc  in  W [0:W-1]  source operands; word i occupies bits [32i +: 32].
REQ-010 reg_write  in  1  instruction writes the register file.
REQ-011 stall  in  1  freeze whole pipeline.
REQ-012 flush  in  1  kill all in-flight instructions.
REQ-013 rt_wb, rt_addr_wb, reg_write_wb  out  W/7/1  short-class writeback port.
REQ-014 rt_int, rt_addr_int, reg_write_int  out  W/7/1  long-class writeback port.

Function
REQ-015 SHALL implement a LAT_L-deep register chain; each stage holds data W, addr 7, reg_write 1, valid 1 and class 1.
REQ-016 SHALL, at each non-stalled edge, advance every stage by one and load stage 0 from the decoded inputs.
REQ-017 SHALL treat format 0 with op[0:9] == 0 as nop: insert a bubble (valid 0, all fields 0).
REQ-018 SHALL decode format 0 as follows; all products are computed per lane:
- mpy 01111000100: signed ra.lo16 * rb.lo16.
- mpyu 01111001100: unsigned ra.lo16 * rb.lo16.
- mpyh 01111000101: (ra.hi16 * rb.lo16) << 16, truncated to 32 bits.
- mpyhh 01111000110: signed ra.hi16 * rb.hi16.
- mpys 01111000111: signed ra.lo16 * rb.lo16, arithmetic shift right 16, sign-extended.
REQ-019 SHALL decode format 1 with op[0:3] == 1100 as mpya: signed ra.lo16 * rb.lo16 + rc word, modulo 2^32.
REQ-020 SHALL assign mpyh and mpys to the short class; mpy, mpyu, mpyhh and mpya SHALL be long class.
REQ-021 SHALL treat any other op/format as unknown: bubble, no output on either port.
REQ-022 SHALL, after the LAT_S-th advancing edge following issue, drive a short-class result on the rt_wb port for one cycle.
REQ-023 SHALL, after the LAT_L-th advancing edge following issue, drive a long-class result on the rt_int port for one cycle.
REQ-024 SHALL drive all fields of a port to zero in any cycle with no valid matching-class entry at that port's stage.
REQ-025 SHALL allow both ports to be valid in the same cycle (short issued at N+1, long issued at N).
REQ-026 SHALL pass reg_write through unchanged; a valid entry with reg_write 0 still drives data and addr.
REQ-027 SHALL, while stall = 1, hold all stages and both output ports and ignore the inputs.
REQ-028 SHALL, on an edge with flush = 1, zero all stages and both ports and drop the current input.
REQ-029 SHALL give flush priority over stall.
REQ-030 SHALL register the outputs; there is no combinational path from inputs to outputs.
REQ-031 SHALL accept back-to-back issue every non-stalled cycle; throughput is one instruction per cycle.

Reset
REQ-032 SHALL, while reset = 0, asynchronously clear all stages and drive every output to 0.
REQ-033 SHALL discard all in-flight instructions if reset is asserted mid-operation.
REQ-034 SHALL sample the first instruction at the first rising edge after reset deasserts.

Verification
REQ-035 mpy, ra words 0x0000FFFF, rb words 0x00000002, rt_addr 5, reg_write 1 -> after edge 7: rt_int all words 0xFFFFFFFE, rt_addr_int 5, reg_write_int 1; rt_wb 0 throughout.
REQ-036 mpys, ra words 0x00004000, rb words 0x00008000 -> after edge 6: rt_wb all words 0xFFFFE000; rt_int stays 0.
REQ-037 mpya issued at N, mpyh at N+1, with ra 0x00030003, rb 0x00050005, rc 0x00000001 -> at the same cycle: rt_int word 0x00000010 and rt_wb word 0x000F0000.
REQ-038 mpy issued, then stall held 3 cycles at stage 2 -> result appears 3 cycles later than unstalled and exactly once.
REQ-039 flush pulsed with 4 instructions in flight -> no further nonzero output on either port; an instruction issued the next cycle completes normally.
REQ-040 unknown opcode, nop, and reset asserted mid-flight -> both ports stay 0; with LANES=8, mpyu on 0xFFFF operands -> every word 0xFFFE0001.
